// File: rtl/z88_bus_sched.sv
// Z88-style shared memory bus scheduler: Z80 owns phases 10/11, the video slot
// (phases 00/01) is granted to the screen, the aux master, or left idle.
//
//   grant    | meaning
//   OWN_Z80  | Z80 slot (phases 10/11, never registered)
//   OWN_SCR  | screen fetch holds the video slot
//   OWN_AUX  | aux access in phase 00, ack in phase 01
//   OWN_IDLE | video slot unused
module z88_bus_sched #(
    parameter int STARVE = 7
) (
    input  logic        mck,
    input  logic        rin,
    input  logic        lcdon,
    output logic [1:0]  clkcnt,
    input  logic [21:0] z_a,
    input  logic        z_mreq,
    input  logic        z_we,
    input  logic [7:0]  z_do,
    input  logic        s_req,
    input  logic [21:0] s_a,
    input  logic        a_req,
    input  logic [21:0] a_a,
    input  logic        a_we,
    input  logic [7:0]  a_do,
    input  logic [7:0]  cdi,
    output logic [21:0] va,
    output logic [7:0]  cdo,
    output logic        we,
    output logic [1:0]  owner,
    output logic        s_gnt,
    output logic        a_ack,
    output logic [7:0]  a_di
);

    typedef enum logic [1:0] {
        OWN_Z80  = 2'b00,
        OWN_SCR  = 2'b01,
        OWN_AUX  = 2'b10,
        OWN_IDLE = 2'b11
    } owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE);

    logic [1:0] r_clkcnt;
    owner_t     r_grant;
    owner_t     w_grant_nxt;
    owner_t     w_owner;
    logic [3:0] r_starve;
    logic [3:0] w_starve_nxt;
    logic       r_ack;
    logic [7:0] r_adi;
    logic       w_decide;
    logic       w_aux_ph0;

    assign w_decide  = (r_clkcnt == 2'b11);
    assign w_owner   = r_clkcnt[1] ? OWN_Z80 : r_grant;
    assign w_aux_ph0 = (r_clkcnt == 2'b00) && (r_grant == OWN_AUX);

    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            r_clkcnt <= 2'b00;
            r_grant  <= OWN_IDLE;
            r_starve <= 4'd0;
            r_ack    <= 1'b0;
            r_adi    <= 8'h00;
        end else begin
            r_clkcnt <= r_clkcnt + 2'd1;
            r_grant  <= w_grant_nxt;
            r_starve <= w_starve_nxt;
            r_ack    <= w_aux_ph0;
            if (w_aux_ph0 && !a_we)
                r_adi <= cdi;
        end
    end

    // Screen has priority unless aux has already waited STARVE slots.
    always_comb begin
        w_grant_nxt  = r_grant;
        w_starve_nxt = r_starve;
        if (w_decide) begin
            if (s_req && lcdon && !(a_req && (r_starve == STARVE_LIM))) begin
                w_grant_nxt = OWN_SCR;
                if (!a_req)
                    w_starve_nxt = 4'd0;
                else if (r_starve != STARVE_LIM)
                    w_starve_nxt = r_starve + 4'd1;
            end else if (a_req) begin
                w_grant_nxt  = OWN_AUX;
                w_starve_nxt = 4'd0;
            end else begin
                w_grant_nxt  = OWN_IDLE;
                w_starve_nxt = 4'd0;
            end
        end
    end

    always_comb begin
        we  = 1'b0;
        cdo = 8'h00;
        if ((r_clkcnt == 2'b11) && z_mreq && z_we) begin
            we  = 1'b1;
            cdo = z_do;
        end else if (w_aux_ph0 && a_we) begin
            we  = 1'b1;
            cdo = a_do;
        end
    end

    always_comb begin
        case (w_owner)
            OWN_Z80: va = z_a;
            OWN_SCR: va = s_a;
            OWN_AUX: va = a_a;
            default: va = 22'd0;
        endcase
    end

    assign clkcnt = r_clkcnt;
    assign owner  = w_owner;
    assign s_gnt  = (w_owner == OWN_SCR);
    assign a_ack  = r_ack;
    assign a_di   = r_adi;

endmodule
